calibration_sequencer: RTL
==========================

Name: calibration_sequencer

Overview:
- Top-level controller for one full LED-position calibration run.
- Steps through every bit plane of the LED ID code. For each plane it asks the LED strand driver to show that plane, waits for light and camera to settle, then gates exactly one camera frame into the shift-accumulate RAM.
- After the last plane it sweeps the accumulator RAM and streams each (pixel address, decoded LED code) pair to the downstream position table over a valid/ready interface.

Parameters:
- CODE_WIDTH, 10: bits per LED ID code; one bit plane per code bit.
- DEPTH, 3600: number of downsampled pixel entries in the accumulator RAM (80x45).
- SETTLE_CYCLES, 10000000: clk_pixel cycles waited after the strand reports a valid frame; must be at least 1.
- READ_LATENCY, 2: fixed cycles from rd_req_out to rd_valid_in; the sequencer does not depend on this value, it is used only by the bench model.
- ADDR_WIDTH (localparam), $clog2(DEPTH).
- BIT_WIDTH (localparam), $clog2(CODE_WIDTH).
- CNT_WIDTH (localparam), $clog2(SETTLE_CYCLES+1).

Ports:
- clk_pixel  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  rising edge starts a run; ignored unless idle or done.
- abort_in  in  1  level; forces return to IDLE.
- displayed_frame_valid_in  in  1  strand driver is showing the requested plane.
- new_frame_in  in  1  single-cycle camera frame-start pulse.
- bit_idx_out  out  BIT_WIDTH  current bit plane; LED i is lit iff bit bit_idx_out of i is 1.
- pattern_req_out  out  1  asks the strand driver to display plane bit_idx_out.
- capture_en_out  out  1  high for exactly one camera frame; the accumulator WRITE enable gate.
- rd_req_out  out  1  one-cycle READ request to the accumulator.
- rd_addr_out  out  ADDR_WIDTH  read address.
- rd_data_in  in  CODE_WIDTH  accumulated code.
- rd_valid_in  in  1  read result valid.
- out_valid  out  1  result stream valid.
- out_ready  in  1  result stream ready.
- out_addr  out  ADDR_WIDTH  pixel address of the result.
- out_code  out  CODE_WIDTH  LED code at that pixel.
- busy_out  out  1  high in any state other than IDLE and DONE.
- done_out  out  1  high in DONE.

Behaviour:
- Reset: state IDLE, bit_idx 0, counter 0, start edge register 0. All outputs 0.
- Start detection: start_in high with a 0 start edge register on the previous cycle. The edge register updates every cycle, including while busy.
- IDLE / DONE
  - On a start edge: bit_idx=0, go to SHOW.
  - DONE holds done_out=1 until the next start edge or until abort_in.
- SHOW: pattern_req_out=1. On displayed_frame_valid_in: counter=0, go to SETTLE.
- SETTLE
  - pattern_req_out stays 1; counter increments every cycle.
  - When counter==SETTLE_CYCLES-1, go to WAIT_FRAME.
  - new_frame_in is ignored in this state.
- WAIT_FRAME: pattern_req_out=1. First new_frame_in pulse goes to CAPTURE.
- CAPTURE
  - capture_en_out=1 from the cycle after the pulse that entered CAPTURE up to and including the cycle of the next new_frame_in pulse. This is exactly one frame.
  - On that closing pulse:
    - If bit_idx==CODE_WIDTH-1: addr=0, go to SWEEP_REQ.
    - Otherwise: bit_idx+1, go to SHOW.
- SWEEP_REQ: rd_req_out=1 for one cycle with rd_addr_out=addr, then go to SWEEP_WAIT.
- SWEEP_WAIT: on rd_valid_in, latch out_addr=addr and out_code=rd_data_in, set out_valid=1, go to SWEEP_OUT.
- SWEEP_OUT
  - Hold out_valid, out_addr and out_code stable until out_valid && out_ready.
  - On that handshake cycle:
    - If addr==DEPTH-1: go to DONE.
    - Otherwise: addr+1, go to SWEEP_REQ.
  - out_valid drops in the cycle after the handshake.
- Only one read is outstanding at a time. Minimum of 3 cycles per entry with out_ready tied high.
- abort_in: has priority over all transitions. Next state is IDLE; all outputs deassert on the following cycle; counters clear.
- Reset mid-run: identical to abort. Capture and sweep progress are discarded.
- new_frame_in coinciding with the SETTLE terminal count: the pulse is not used; WAIT_FRAME waits for the following pulse.
- Counter arithmetic: no wrap-around is reachable, because bit_idx and addr terminate at their limits.

Optional Feature:
- Macro: CAL_SKIP_ZERO_EN.
- Defined: in SWEEP_WAIT, a result with rd_data_in==0 is not emitted.
  - Not last entry: addr+1, go to SWEEP_REQ.
  - Last entry (DEPTH-1): go to DONE.
- Undefined: all DEPTH entries are emitted, including zero codes.

Test Plan:
- Full run, CODE_WIDTH=3, SETTLE_CYCLES=4, DEPTH=8, strand valid 2 cycles after each request:
  - Required: capture_en_out high for exactly 3 frame windows, with bit_idx_out 0, 1, 2 in turn.
  - Required: 8 outputs with out_addr 0..7 in order; done_out=1 after the last handshake.
- Frame pulses at settle cycles 1 and 3 -> ignored; capture starts only on the first pulse seen in WAIT_FRAME.
- out_ready low for 5 cycles on entry 2, RAM model returning code 5 -> out_valid, out_addr=2 and out_code=5 held stable for all 5 cycles; no rd_req_out issued until the handshake.
- abort_in pulse during CAPTURE of bit 1, then during SWEEP_OUT of entry 4 -> outputs 0 on the next cycle, state IDLE; a new start runs from bit 0 or entry 0 respectively.
- start_in held high through a run, and re-pulsed mid-run -> exactly one run; the mid-run pulse is ignored.
- CAL_SKIP_ZERO_EN defined, RAM model returning codes {0,3,0,0,7,0,0,1} -> exactly 3 outputs: (1,3), (4,7), (7,1); then DONE.

Source files
------------

// File: rtl/calibration_sequencer.sv
// Calibration run controller: shows each LED ID bit plane, gates one camera frame per plane,
// then sweeps the accumulator RAM out as (address, code) pairs. Optional `CAL_SKIP_ZERO_EN drops zero codes.
`timescale 1ns/1ps
module calibration_sequencer #(
  parameter int CODE_WIDTH    = 10,
  parameter int DEPTH         = 3600,
  parameter int SETTLE_CYCLES = 10000000,
  parameter int READ_LATENCY  = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BIT_WIDTH  = $clog2(CODE_WIDTH),
  localparam int CNT_WIDTH  = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  displayed_frame_valid_in,
  input  logic                  new_frame_in,
  output logic [BIT_WIDTH-1:0]  bit_idx_out,
  output logic                  pattern_req_out,
  output logic                  capture_en_out,
  output logic                  rd_req_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [CODE_WIDTH-1:0] rd_data_in,
  input  logic                  rd_valid_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [CODE_WIDTH-1:0] out_code,
  output logic                  busy_out,
  output logic                  done_out
);

  if (SETTLE_CYCLES < 1 || READ_LATENCY < 1) begin : g_bad_param
    $error("calibration_sequencer: SETTLE_CYCLES and READ_LATENCY must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_SHOW, S_SETTLE, S_WAIT_FRAME, S_CAPTURE,
    S_SWEEP_REQ, S_SWEEP_WAIT, S_SWEEP_OUT, S_DONE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [BIT_WIDTH-1:0]  r_bit_idx, w_bit_idx_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_out_addr, w_out_addr_nxt;
  logic [CODE_WIDTH-1:0] r_out_code, w_out_code_nxt;
  logic                  r_start_d;
  logic                  w_start_edge;
  logic                  w_last_bit;
  logic                  w_last_addr;

  assign w_start_edge = start_in && !r_start_d;
  assign w_last_bit   = (r_bit_idx == BIT_WIDTH'(CODE_WIDTH - 1));
  assign w_last_addr  = (r_addr == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_addr     <= '0;
      r_out_addr <= '0;
      r_out_code <= '0;
      r_start_d  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_out_addr <= w_out_addr_nxt;
      r_out_code <= w_out_code_nxt;
      r_start_d  <= start_in;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_addr_nxt     = r_addr;
    w_out_addr_nxt = r_out_addr;
    w_out_code_nxt = r_out_code;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_edge) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_SHOW;
        end
      end
      S_SHOW: begin
        if (displayed_frame_valid_in) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Frame pulses here are deliberately dropped, even on the terminal count.
        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        if (r_cnt == CNT_WIDTH'(SETTLE_CYCLES - 1)) w_state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (new_frame_in) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (new_frame_in) begin
          if (w_last_bit) begin
            w_addr_nxt  = '0;
            w_state_nxt = S_SWEEP_REQ;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_WIDTH'(1);
            w_state_nxt   = S_SHOW;
          end
        end
      end
      S_SWEEP_REQ: w_state_nxt = S_SWEEP_WAIT;
      S_SWEEP_WAIT: begin
        if (rd_valid_in) begin
`ifdef CAL_SKIP_ZERO_EN
          if (rd_data_in == '0) begin
            if (w_last_addr) begin
              w_state_nxt = S_DONE;
            end else begin
              w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
              w_state_nxt = S_SWEEP_REQ;
            end
          end else begin
            w_out_addr_nxt = r_addr;
            w_out_code_nxt = rd_data_in;
            w_state_nxt    = S_SWEEP_OUT;
          end
`else
          w_out_addr_nxt = r_addr;
          w_out_code_nxt = rd_data_in;
          w_state_nxt    = S_SWEEP_OUT;
`endif
        end
      end
      S_SWEEP_OUT: begin
        if (out_ready) begin
          if (w_last_addr) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            w_state_nxt = S_SWEEP_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over every transition and discards all progress.
    if (abort_in) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = '0;
      w_bit_idx_nxt  = '0;
      w_addr_nxt     = '0;
      w_out_addr_nxt = '0;
      w_out_code_nxt = '0;
    end
  end

  assign bit_idx_out     = r_bit_idx;
  assign pattern_req_out = (r_state == S_SHOW) || (r_state == S_SETTLE) || (r_state == S_WAIT_FRAME);
  assign capture_en_out  = (r_state == S_CAPTURE);
  assign rd_req_out      = (r_state == S_SWEEP_REQ);
  assign rd_addr_out     = r_addr;
  assign out_valid       = (r_state == S_SWEEP_OUT);
  assign out_addr        = r_out_addr;
  assign out_code        = r_out_code;
  assign busy_out        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_out        = (r_state == S_DONE);

endmodule
